// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and helpers for the instruction fetch unit and its prefetch queue.
package arm_fetch_pkg;

  localparam int PC_WIDTH    = 64;
  localparam int INSTR_WIDTH = 32;
  localparam int INSTR_BYTES = 4;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    FAULT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_WIDTH-1:0] instr;
    logic [PC_WIDTH-1:0]    pc;
  } fetch_entry_t;

  // Evaluated one bit wider than the PC so that pc+3 near 2^64 cannot wrap into a legal range.
  function automatic logic pc_in_range(input logic [PC_WIDTH-1:0] pc,
                                       input logic [PC_WIDTH:0]   mem_limit);
    logic [PC_WIDTH:0] last_byte;
    last_byte = {1'b0, pc} + (PC_WIDTH + 1)'(INSTR_BYTES - 1);
    return last_byte < mem_limit;
  endfunction

  function automatic logic target_legal(input logic [PC_WIDTH-1:0] target,
                                        input logic [PC_WIDTH:0]   mem_limit);
    return (target[1:0] == 2'b00) && pc_in_range(target, mem_limit);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of {instr, pc} prefetch entries with push, pop and flush.
module fetch_queue
  import arm_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             wr_entry,
  output fetch_entry_t             rd_entry,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_CNT = (PW + 1)'(DEPTH);
  localparam logic [PW:0] ONE_CNT   = (PW + 1)'(1);
  localparam logic [PW-1:0] ONE_PTR = PW'(1);

  fetch_entry_t    entries [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            full;
  logic            do_push;
  logic            do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_CNT);
  // A push into a full queue is legal only when the head leaves on the same edge.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ONE_PTR;
      if (do_pop)  rd_ptr <= rd_ptr + ONE_PTR;
      case ({do_push, do_pop})
        2'b10:   count <= count + ONE_CNT;
        2'b01:   count <= count - ONE_CNT;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) entries[wr_ptr] <= wr_entry;
  end

  assign rd_entry = empty ? '0 : entries[rd_ptr];

endmodule

// File: rtl/instruction_fetch_unit.sv
// Owns the PC, fetches from combinational instruction memory into the prefetch queue and
// handles branch redirects, back-pressure and fetch faults.
module instruction_fetch_unit
  import arm_fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC    = 64'h0,
  parameter int          MEM_SIZE    = 256,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [63:0] imem_address,
  input  logic [31:0] imem_data,
  input  logic        redirect,
  input  logic [63:0] redirect_target,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [63:0] instr_pc,
  output logic        fetch_fault,
  output logic [63:0] fault_pc
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [CW-1:0]     DEPTH_CNT = CW'(QUEUE_DEPTH);
  localparam logic [PC_WIDTH:0] MEM_LIMIT = (PC_WIDTH + 1)'(MEM_SIZE);

  logic [PC_WIDTH-1:0] pc;
  fetch_state_t        state;
  logic                push;
  logic                pop;
  logic                flush;
  logic                queue_empty;
  logic [CW-1:0]       queue_count;
  fetch_entry_t        head;
  fetch_entry_t        fetched;
  logic                pc_ok;
  logic                target_ok;

  assign pc_ok     = pc_in_range(pc, MEM_LIMIT);
  assign target_ok = target_legal(redirect_target, MEM_LIMIT);
  assign pop       = instr_valid && instr_ready;
  assign fetched   = '{instr: imem_data, pc: pc};

  always_comb begin
    push  = 1'b0;
    flush = 1'b0;
    if (redirect) begin
      flush = 1'b1;
    end else if (state == FETCH && pc_ok && (queue_count < DEPTH_CNT || pop)) begin
      push = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      state    <= FETCH;
      fault_pc <= '0;
    end else if (redirect) begin
      if (target_ok) begin
        pc    <= redirect_target;
        state <= FETCH;
      end else begin
        state    <= FAULT;
        fault_pc <= redirect_target;
      end
    end else if (state == FETCH) begin
      if (!pc_ok) begin
        state    <= FAULT;
        fault_pc <= pc;
      end else if (push) begin
        pc <= pc + PC_WIDTH'(INSTR_BYTES);
      end
    end
  end

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .pop      (pop),
    .flush    (flush),
    .wr_entry (fetched),
    .rd_entry (head),
    .empty    (queue_empty),
    .count    (queue_count)
  );

  assign imem_address = pc;
  assign instr_valid  = !queue_empty;
  assign instr        = head.instr;
  assign instr_pc     = head.pc;
  assign fetch_fault  = (state == FAULT);

endmodule
